fifo_rd_bridge: RTL and testbench
=================================

FIFO_RD_BRIDGE -- requirements
Module: fifo_rd_bridge

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, meaning the data word width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, fixed at 2, meaning the number of entries in the output skid buffer.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port data_out, input, FIFO_WIDTH bits: the FIFO read data, registered by the FIFO one edge after rd_en is sampled.
REQ-006 SHALL have port empty, input, 1 bit: the FIFO empty flag.
REQ-007 SHALL have port underflow, input, 1 bit: the FIFO underflow flag, valid in the cycle after a read attempted while empty.
REQ-008 SHALL have port rd_en, output, 1 bit: the FIFO read request.
REQ-009 SHALL have port m_data, output, FIFO_WIDTH bits: the downstream data.
REQ-010 SHALL have port m_valid, output, 1 bit: the downstream data is valid.
REQ-011 SHALL have port m_ready, input, 1 bit: the downstream accepts data.
REQ-012 SHALL have port underflow_err, output, 1 bit: sticky flag set when an underflow is detected.

Function
REQ-013 SHALL hold internal state: a 2-entry FIFO-ordered buffer, occ (0..2), and inflight (1 bit, set when rd_en was high on the previous edge).
REQ-014 SHALL drive rd_en = !empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready; rd_en is combinational from registered state and inputs.
REQ-015 SHALL, on an edge with inflight=1 and underflow=0, capture data_out into the buffer tail.
REQ-016 SHALL, on an edge with inflight=1 and underflow=1, discard data_out and set underflow_err.
REQ-017 SHALL drive m_valid = (occ != 0) and m_data = the buffer head; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-018 SHALL, on pop, remove the head; a simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-019 SHALL never let occ exceed 2 and never let occ underflow; the rd_en rule guarantees capacity for every in-flight word.
REQ-020 SHALL have a latency of 2 cycles from empty falling (with occ=0) to m_valid rising.
REQ-021 SHALL sustain 1 word/cycle when the FIFO is non-empty and m_ready is held high.
REQ-022 SHALL keep m_valid asserted when empty rises, until the buffered words are popped.
REQ-023 SHALL keep underflow_err set until reset.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force occ=0, inflight=0, underflow_err=0, m_valid=0, m_data=0, and rd_en=0 (rd_en gated by rst_n).
REQ-025 SHALL, on reset asserted mid-transfer, lose buffered and in-flight words; after release, the first capture occurs no earlier than 2 edges after the first rd_en.

Configuration
REQ-026 SHALL, when macro FIFO_RD_BRIDGE_STATS_EN is defined, add output rd_count (16 bits), which increments on each pop, wraps 0xFFFF->0x0000, and resets to 0.
REQ-027 SHALL, when FIFO_RD_BRIDGE_STATS_EN is undefined, not have the rd_count port or its counter logic; all other behaviour is identical.

Verification
REQ-028 Scenario: FIFO preloaded with 0x0001..0x0008, m_ready=1 -> m_valid rises 2 cycles after the first rd_en; eight consecutive beats 0x0001..0x0008 with no bubbles.
REQ-029 Scenario: 4 words queued, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses, occ=2, m_data=first word stable; on release, all 4 words arrive in order.
REQ-030 Scenario: m_ready toggles 1/0 each cycle over 8 words -> no loss or duplication; rd_en never issued when occ+inflight-pop=2.
REQ-031 Scenario: force underflow=1 in the cycle after an rd_en -> word discarded, occ unchanged, underflow_err=1 until rst_n pulses low.
REQ-032 Scenario: rst_n asserted low with occ=2 and inflight=1 -> m_valid=0 and rd_en=0 immediately (no clock edge needed); clean restart after release.
REQ-033 Scenario (STATS_EN defined): 65537 pops -> rd_count=0x0001.

Source files
------------

// File: rtl/fifo_rd_bridge.sv
// Read-side bridge from a registered-output FIFO to a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_RD_BRIDGE_STATS_EN to add the rd_count pop counter output.
module fifo_rd_bridge #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_BRIDGE_STATS_EN
  output logic [15:0]           rd_count,
`endif
  output logic                  underflow_err
);

  logic [FIFO_WIDTH-1:0] skid_mem [2];
  logic [1:0]            occ;
  logic                  head_ptr;
  logic                  tail_ptr;
  logic                  vld_p1;
  logic                  pop;
  logic                  capture;
  logic                  discard;
  logic [2:0]            level;

  // p0: issue a read only if the word it returns is guaranteed a slot
  assign pop     = m_valid && m_ready;
  assign level   = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en   = rst_n && !empty && (level < 3'(BUF_DEPTH));

  // p1: the FIFO word requested last edge is presented now
  assign capture = vld_p1 && !underflow;
  assign discard = vld_p1 && underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      occ           <= 2'd0;
      head_ptr      <= 1'b0;
      tail_ptr      <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      vld_p1        <= rd_en;
      occ           <= occ + {1'b0, capture} - {1'b0, pop};
      head_ptr      <= head_ptr ^ pop;
      tail_ptr      <= tail_ptr ^ capture;
      underflow_err <= underflow_err | discard;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      skid_mem[tail_ptr] <= data_out;
    end
  end

  // p2: buffer head drives the stream; zeroed whenever nothing is held
  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? skid_mem[head_ptr] : '0;

`ifdef FIFO_RD_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
    end else if (pop) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_bridge.sv
// Directed bench for fifo_rd_bridge: behavioural FIFO source, stream sink and rd_en rule monitor.
module tb_fifo_rd_bridge;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_out = '0;
  logic         empty;
  logic         underflow;
  logic         rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         underflow_err;
`ifdef FIFO_RD_BRIDGE_STATS_EN
  logic [15:0]  rd_count;
`endif

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] mem [64];
  int           wr_idx = 0;
  int           rd_idx = 0;
  bit           src_inf = 1'b0;
  bit           force_uf = 1'b0;
  logic         uf_r = 1'b0;
  int           outst = 0;
  logic         inf_tb = 1'b0;
  logic [W-1:0] obs_q [$];
  int           base;
  int           cnt;
  int           npop;

  fifo_rd_bridge #(.FIFO_WIDTH(W), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_out     (data_out),
    .empty        (empty),
    .underflow    (underflow),
    .rd_en        (rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
`ifdef FIFO_RD_BRIDGE_STATS_EN
    .rd_count     (rd_count),
`endif
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  assign empty     = src_inf ? 1'b0 : (wr_idx == rd_idx);
  assign underflow = uf_r | force_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wr_idx[5:0]] = d;
    wr_idx++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_ready  = 1'b0;
    force_uf = 1'b0;
    src_inf  = 1'b0;
    tick();
    wr_idx = rd_idx;
    tick();
  endtask

  // FIFO with registered read data
  always @(posedge clk) begin
    uf_r <= rd_en && empty;
    if (rd_en && !empty) begin
      data_out <= src_inf ? W'(rd_idx) : mem[rd_idx[5:0]];
      rd_idx   <= rd_idx + 1;
    end
  end

  // words requested and not yet popped or discarded
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst  <= 0;
      inf_tb <= 1'b0;
    end else begin
      outst  <= outst + int'(rd_en) - int'(m_valid && m_ready) - int'(inf_tb && underflow);
      inf_tb <= rd_en;
    end
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) obs_q.push_back(m_data);
    chk("rd_en_rule", rd_en, rst_n && !empty && ((outst - int'(m_valid && m_ready)) < 2));
  end

  initial begin
    for (int k = 0; k < 8; k++) push(W'(k + 1));
    tick();
    tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", underflow_err, 0);
    chk("rst_occ", dut.occ, 0);

    // streaming at full rate
    m_ready = 1'b1;
    base = obs_q.size();
    rst_n = 1'b1;
    #1;
    chk("s1_first_rd_en", rd_en, 1);
    chk("s1_vld_t0", m_valid, 0);
    tick();
    chk("s1_vld_t1", m_valid, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("s1_beat_valid", m_valid, 1);
      chk("s1_beat_data", m_data, k + 1);
      tick();
    end
    chk("s1_drained", m_valid, 0);
    chk("s1_count", obs_q.size() - base, 8);

    // backpressure holds two words
    do_reset();
    for (int k = 0; k < 4; k++) push(W'(16'hA1 + k));
    rst_n = 1'b1;
    #1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_en) cnt++;
      if (k >= 2) chk("s2_hold", m_data, 16'hA1);
      tick();
    end
    chk("s2_rd_pulses", cnt, 2);
    chk("s2_occ", dut.occ, 2);
    chk("s2_valid", m_valid, 1);
    chk("s2_data", m_data, 16'hA1);
    base = obs_q.size();
    m_ready = 1'b1;
    repeat (8) tick();
    chk("s2_count", obs_q.size() - base, 4);
    for (int k = 0; k < 4; k++) chk("s2_order", obs_q[base + k], 16'hA1 + k);

    // toggling ready
    do_reset();
    for (int k = 0; k < 8; k++) push(W'(16'h11 + k));
    base = obs_q.size();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      m_ready = k[0];
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("s3_count", obs_q.size() - base, 8);
    for (int k = 0; k < 8; k++) chk("s3_order", obs_q[base + k], 16'h11 + k);

    // underflow discards the in-flight word
    do_reset();
    push(16'h31);
    push(16'h32);
    push(16'h33);
    rst_n = 1'b1;
    #1;
    tick();
    force_uf = 1'b1;
    tick();
    force_uf = 1'b0;
    chk("s4_occ", dut.occ, 0);
    chk("s4_err", underflow_err, 1);
    chk("s4_valid0", m_valid, 0);
    tick();
    chk("s4_valid1", m_valid, 1);
    chk("s4_data", m_data, 16'h32);
    base = obs_q.size();
    m_ready = 1'b1;
    repeat (5) tick();
    chk("s4_count", obs_q.size() - base, 2);
    chk("s4_order0", obs_q[base], 16'h32);
    chk("s4_order1", obs_q[base + 1], 16'h33);
    chk("s4_err_sticky", underflow_err, 1);
    rst_n = 1'b0;
    #1;
    chk("s4_err_clr", underflow_err, 0);

    // reset mid-transfer, no clock edge needed
    do_reset();
    for (int k = 0; k < 6; k++) push(W'(16'h51 + k));
    rst_n = 1'b1;
    #1;
    tick();
    tick();
    chk("s5_pre_valid", m_valid, 1);
    chk("s5_pre_inflight", dut.vld_p1, 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", m_valid, 0);
    chk("s5_rst_rd_en", rd_en, 0);
    chk("s5_rst_data", m_data, 0);
    chk("s5_rst_occ", dut.occ, 0);
    tick();
    base = obs_q.size();
    m_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("s5_restart_rd", rd_en, 1);
    tick();
    chk("s5_restart_vld1", m_valid, 0);
    tick();
    chk("s5_restart_vld2", m_valid, 1);
    chk("s5_restart_data", m_data, 16'h53);
    repeat (6) tick();
    chk("s5_count", obs_q.size() - base, 4);
    for (int k = 0; k < 4; k++) chk("s5_order", obs_q[base + k], 16'h53 + k);

`ifdef FIFO_RD_BRIDGE_STATS_EN
    do_reset();
    chk("st_rst", rd_count, 0);
    src_inf = 1'b1;
    m_ready = 1'b1;
    rst_n = 1'b1;
    npop = 0;
    for (int c = 0; c < 70000 && npop < 65537; c++) begin
      if (m_valid) npop++;
      tick();
    end
    m_ready = 1'b0;
    #1;
    chk("st_pops", npop, 65537);
    chk("st_wrap", rd_count, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
